// File: rtl/i2c_master_seq.sv
// Sequencing I2C master: START, address byte, N data bytes with ACK handling, STOP.
// Open-drain SCL/SDA are driven from registered enables, so every bus edge trails the phase counters by one clk.
module i2c_master_seq #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [6:0] i_chip_addr,
    input  logic       i_rw,
    input  logic [3:0] i_nb_bytes,
    input  logic [7:0] i_wdata,
    output logic       o_wdata_req,
    output logic [7:0] o_rdata,
    output logic       o_rdata_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    inout  wire        scl,
    inout  wire        sda
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
    } state_t;

    state_t        state_r, nxt_state_s;
    logic [QW-1:0] q_cnt_r;
    logic [1:0]    phase_r;
    logic [2:0]    bit_cnt_r;
    logic [3:0]    byte_cnt_r;
    logic [7:0]    shift_r;
    logic          rw_r, samp_r;
    logic          scl_oe_r, sda_oe_r;
    logic          busy_r, done_r, nack_r, wreq_r, rvalid_r;
    logic [7:0]    rdata_r;
    logic          q_last_s, slot_end_s, sample_s, tx_bit_s, sda_in_s;
    logic          scl_drv_s, sda_drv_s;

    assign scl      = scl_oe_r ? 1'b0 : 1'bz;
    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign sda_in_s = sda;

    assign o_wdata_req   = wreq_r;
    assign o_rdata       = rdata_r;
    assign o_rdata_valid = rvalid_r;
    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_nack        = nack_r;

    assign q_last_s   = (q_cnt_r == QW'(CLK_DIV - 1));
    assign slot_end_s = q_last_s && (phase_r == 2'd3);
    assign sample_s   = q_last_s && (phase_r == 2'd2);
    // The write byte is only loaded at the end of the request cycle, so bypass it for bit 7.
    assign tx_bit_s   = wreq_r ? i_wdata[7] : shift_r[7];

    // Next-state logic: transitions happen only at the end of a full bit slot.
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            IDLE:     nxt_state_s = i_start ? START : IDLE;
            START:    nxt_state_s = slot_end_s ? ADDR : START;
            ADDR:     nxt_state_s = (slot_end_s && bit_cnt_r == 3'd0) ? ADDR_ACK : ADDR;
            ADDR_ACK: begin
                if (!slot_end_s) begin
                    nxt_state_s = ADDR_ACK;
                end else if (samp_r || byte_cnt_r == 4'd0) begin
                    nxt_state_s = STOP;
                end else begin
                    nxt_state_s = rw_r ? RD_BYTE : WR_BYTE;
                end
            end
            WR_BYTE:  nxt_state_s = (slot_end_s && bit_cnt_r == 3'd0) ? WR_ACK : WR_BYTE;
            WR_ACK: begin
                if (!slot_end_s) begin
                    nxt_state_s = WR_ACK;
                end else begin
                    nxt_state_s = (samp_r || byte_cnt_r == 4'd1) ? STOP : WR_BYTE;
                end
            end
            RD_BYTE:  nxt_state_s = (slot_end_s && bit_cnt_r == 3'd0) ? RD_ACK : RD_BYTE;
            RD_ACK: begin
                if (!slot_end_s) begin
                    nxt_state_s = RD_ACK;
                end else begin
                    nxt_state_s = (byte_cnt_r == 4'd1) ? STOP : RD_BYTE;
                end
            end
            STOP:     nxt_state_s = slot_end_s ? IDLE : STOP;
            default:  nxt_state_s = IDLE;
        endcase
    end

    // Bus drive decode (1 = pull the line low) from the current state and phase.
    always_comb begin
        scl_drv_s = 1'b0;
        sda_drv_s = 1'b0;
        case (state_r)
            IDLE: begin
                scl_drv_s = 1'b0;
                sda_drv_s = 1'b0;
            end
            START: begin
                scl_drv_s = 1'b0;
                sda_drv_s = phase_r[1];
            end
            ADDR, WR_BYTE: begin
                scl_drv_s = ~phase_r[1];
                sda_drv_s = ~tx_bit_s;
            end
            ADDR_ACK, WR_ACK, RD_BYTE: begin
                scl_drv_s = ~phase_r[1];
                sda_drv_s = 1'b0;
            end
            RD_ACK: begin
                scl_drv_s = ~phase_r[1];
                sda_drv_s = (byte_cnt_r != 4'd1);
            end
            STOP: begin
                scl_drv_s = (phase_r == 2'd0);
                sda_drv_s = (phase_r != 2'd3);
            end
            default: begin
                scl_drv_s = 1'b0;
                sda_drv_s = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            q_cnt_r    <= QW'(0);
            phase_r    <= 2'd0;
            bit_cnt_r  <= 3'd7;
            byte_cnt_r <= 4'd0;
            shift_r    <= 8'h00;
            rw_r       <= 1'b0;
            samp_r     <= 1'b1;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            nack_r     <= 1'b0;
            wreq_r     <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 8'h00;
        end else begin
            state_r  <= nxt_state_s;
            scl_oe_r <= scl_drv_s;
            sda_oe_r <= sda_drv_s;
            busy_r   <= (nxt_state_s != IDLE);
            done_r   <= (state_r == STOP) && slot_end_s;
            wreq_r   <= (nxt_state_s == WR_BYTE) && (state_r != WR_BYTE);
            rvalid_r <= (state_r == RD_BYTE) && slot_end_s && (bit_cnt_r == 3'd0);

            if (state_r == IDLE) begin
                q_cnt_r   <= QW'(0);
                phase_r   <= 2'd0;
                bit_cnt_r <= 3'd7;
                if (i_start) begin
                    shift_r    <= {i_chip_addr, i_rw};
                    rw_r       <= i_rw;
                    byte_cnt_r <= i_nb_bytes;
                    nack_r     <= 1'b0;
                end
            end else begin
                q_cnt_r <= q_last_s ? QW'(0) : q_cnt_r + QW'(1);
                if (q_last_s) begin
                    phase_r <= phase_r + 2'd1;
                end
                if (sample_s) begin
                    samp_r <= sda_in_s;
                end

                if (wreq_r) begin
                    shift_r <= i_wdata;
                end else if (state_r == RD_BYTE && sample_s) begin
                    shift_r <= {shift_r[6:0], sda_in_s};
                end else if ((state_r == ADDR || state_r == WR_BYTE) && slot_end_s) begin
                    shift_r <= {shift_r[6:0], 1'b0};
                end

                if ((state_r == ADDR || state_r == WR_BYTE || state_r == RD_BYTE) && slot_end_s) begin
                    bit_cnt_r <= bit_cnt_r - 3'd1;
                end
                if (state_r == RD_BYTE && slot_end_s && bit_cnt_r == 3'd0) begin
                    rdata_r <= shift_r;
                end
                if ((state_r == WR_ACK || state_r == RD_ACK) && slot_end_s) begin
                    byte_cnt_r <= byte_cnt_r - 4'd1;
                end
                if ((state_r == ADDR_ACK || state_r == WR_ACK) && slot_end_s && samp_r) begin
                    nack_r <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/i2c_master_seq.md
# i2c_master_seq

Sequencing I2C master that drives the shared open-drain SCL/SDA pair in the I2C test environment. It accepts a one-shot command (chip address, direction, byte count) and generates START, the address byte, the data bytes with ACK handling, and STOP, exchanging data with the user through a per-byte request/valid handshake. It is the stimulus-side counterpart of the I2C slave models and drives transactions onto the bus those models observe.

## Interface
- CLK_DIV, 4, clk cycles per SCL quarter-period (≥2); SCL period = 4*CLK_DIV clk cycles.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  command pulse; accepted only when o_busy=0
- i_chip_addr  in  7  slave address, latched on accepted i_start
- i_rw  in  1  0 = write, 1 = read; latched on accepted i_start
- i_nb_bytes  in  4  data bytes 0..15; 0 = address-only probe; latched on accepted i_start
- i_wdata  in  8  write byte, sampled in the cycle o_wdata_req=1
- o_wdata_req  out  1  one-cycle request for next write byte
- o_rdata  out  8  last received byte, held until next o_rdata_valid
- o_rdata_valid  out  1  one-cycle strobe, o_rdata valid
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle end-of-transaction strobe
- o_nack  out  1  slave NACK seen in last transaction; cleared on accepted i_start
- scl  inout  1  open-drain: driven 0 or released (z)
- sda  inout  1  open-drain: driven 0 or released (z); external pull-up

## Operation
- FSM states: IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP.
- Quarter counter (0..CLK_DIV-1) and phase counter (q0..q3) advance each state; bit counter 7..0, MSB first; byte counter counts down from latched i_nb_bytes.
- IDLE: scl and sda released. Accepted i_start -> START.
- START: q0-q1 both released; q2-q3 sda driven 0, scl released; then ADDR.
- Bit slot (ADDR/WR/RD/ACK states): q0-q1 scl driven 0, sda updated at first cycle of q0; q2-q3 scl released; sda sampled on last cycle of q2.
- ADDR shifts {chip_addr, rw}. ADDR_ACK: sda released, sampled 1 -> o_nack=1, STOP; sampled 0 -> nb_bytes=0: STOP; rw=0: WR_BYTE; rw=1: RD_BYTE.
- WR_BYTE: o_wdata_req pulses on the first cycle of the byte; i_wdata loaded into the shift register in the same cycle. WR_ACK: NACK -> o_nack=1, STOP; ACK -> next WR_BYTE or STOP when count exhausted.
- RD_BYTE: sda released, 8 bits shifted in. o_rdata/o_rdata_valid are updated on the last cycle of the 8th bit's q3. RD_ACK: master drives 0 (ACK) unless last byte, then releases sda (NACK). Then RD_BYTE or STOP.
- STOP: q0 scl 0, sda 0; q1-q2 scl released, sda 0; q3 both released. Then o_done=1, o_busy=0, -> IDLE.
- No clock stretching or arbitration; scl is never sampled.
- i_start while o_busy=1 is ignored; command inputs are not re-sampled.

## Timing
- Reset values: o_busy=0, o_done=0, o_nack=0, o_wdata_req=0, o_rdata_valid=0, o_rdata=0x00, scl/sda released.
- o_busy rises the cycle after accepted i_start. The START phase begins the same cycle.
- Full transaction length N bytes, no NACK: 4*CLK_DIV*(2 + 9*(1+N)) cycles from o_busy rise to o_done.
- NACK abort: STOP begins immediately after the NACK slot; remaining bytes are skipped, with no further o_wdata_req.
- o_done and o_busy fall are coincident; a new i_start is accepted in that same cycle.
- rst_n low mid-transaction: on the next clk edge, reset values are restored and both lines are released. No STOP is generated and there is no o_done.

## Test plan
- CLK_DIV=4, write 2 bytes (0x11, 0x22) to 0x50, slave ACKs all -> SDA bytes 0xA0, 0x11, 0x22; 2 o_wdata_req pulses; o_done 464 cycles after o_busy; o_nack=0.
- Address 0x23, slave never ACKs -> STOP right after ACK slot; no o_wdata_req; o_nack=1; o_done at cycle 176.
- Read 3 bytes from 0x50, slave returns 0xA5, 0x5A, 0xFF -> 3 o_rdata_valid pulses with these values; master ACK, ACK, NACK; control byte 0xA1.
- Write 3 bytes, slave NACKs byte 1 -> 1 o_wdata_req, STOP after byte-1 ACK slot, o_nack=1; next accepted i_start clears o_nack.
- Probe (i_nb_bytes=0) with i_start re-pulsed mid-transaction -> second pulse ignored; single o_done at 176 cycles.
- rst_n low during 4th address bit -> next edge: scl/sda z, o_busy=0, no o_done; a fresh command afterwards completes normally.
